hazard_stall_ctrl: RTL

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_pkg.sv | 12 +
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stateT;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the EX load and the ID consumer.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRt,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idMemWrite,
  output logic                  loadUse
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRt == idRs);
  // A store's data operand is forwarded WB->MEM, so it never needs a bubble.
  assign rtMatch = (exRt == idRt) && !idMemWrite;

  assign loadUse = exMemRead && (exRt != '0) && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use bubble, branch flush.
// Optional saturating stall counter enabled by HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ID_EX_MemRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
  input  logic                  IF_ID_MemWrite,
  input  logic                  ID_BranchTaken,
  input  logic                  EX_MEM_MemAccess,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble,
  output logic                  IF_ID_Flush,
  output logic                  Pipe_Freeze
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  stateT stateReg;
  stateT stateNext;
  logic  loadUse;
  logic  memStall;

  load_use_detect uLoadUse (
    .exMemRead  (ID_EX_MemRead),
    .exRt       (ID_EX_RegisterRt),
    .idRs       (IF_ID_RegisterRs),
    .idRt       (IF_ID_RegisterRt),
    .idMemWrite (IF_ID_MemWrite),
    .loadUse    (loadUse)
  );

  assign memStall = EX_MEM_MemAccess && !mem_ready;

  always_comb begin
    stateNext    = stateReg;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    Pipe_Freeze  = 1'b0;
    // While in reset the outputs stay at their run-through values.
    if (!reset) begin
      case (stateReg)
        RUN: begin
          if (memStall) begin
            Pipe_Freeze = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            stateNext   = MEM_WAIT;
          end else if (loadUse) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end else if (ID_BranchTaken) begin
            IF_ID_Flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            Pipe_Freeze = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
          end else begin
            stateNext = RUN;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stallCountReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCountReg <= '0;
    end else if (!PCWrite && (stallCountReg != {STALL_CNT_W{1'b1}})) begin
      stallCountReg <= stallCountReg + 1'b1;
    end
  end

  assign stall_count = stallCountReg;
`endif

endmodule
